t2mi_ts_mux: RTL and testbench

- Multi-stream successor to the single-stream T2-MI-over-TS encapsulator.
- Takes NUM_STREAMS independent T2-MI byte streams, each from its own packet former and FIFO, and packs them into 188-byte TS packets on one output.
- Each stream has a runtime PID and its own 4-bit continuity counter. Grants are round-robin.
- When no stream is ready, emits null packets (optional) to keep the output rate constant. Sits between the per-stream T2-MI packet formers and the ASI/TS output stage.

---
 rtl/t2mi_ts_mux.sv | 213 +++++++++++++++++++++
 tb/tb_t2mi_ts_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/t2mi_ts_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : t2mi_ts_mux
// Purpose  : Round-robin multiplexer packing several T2-MI byte streams into
//            188-byte TS packets, with per-stream PID/CC and null-packet fill.
// Revision : 1.0 - initial release
// ============================================================================
module t2mi_ts_mux #(
    parameter int NUM_STREAMS = 4,
    parameter bit NULL_FILL   = 1'b1,
    parameter int GAP         = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_STREAMS-1:0]     enable,
    input  logic [NUM_STREAMS-1:0]     ready,
    input  logic [NUM_STREAMS-1:0]     pusi,
    input  logic [8*NUM_STREAMS-1:0]   pointer_in,
    input  logic [13*NUM_STREAMS-1:0]  pid_in,
    input  logic [8*NUM_STREAMS-1:0]   data_in,
    output logic [NUM_STREAMS-1:0]     rd_req,
    output logic [7:0]                 data_out,
    output logic                       ena_out,
    output logic                       psync_out,
    output logic [2:0]                 grant_id
);

    localparam int          c_sel_w    = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [7:0]  c_sync     = 8'h47;
    localparam logic [7:0]  c_last     = 8'd187;
    localparam logic [7:0]  c_last_rd  = 8'd185;
    localparam logic [12:0] c_null_pid = 13'h1FFF;
    localparam logic [3:0]  c_gap_init = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PTR     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [3:0]           r_gap;
    logic [c_sel_w-1:0]   r_rr;
    logic [c_sel_w-1:0]   r_sel;
    logic                 r_null;
    logic [12:0]          r_pid;
    logic                 r_pusi;
    logic [7:0]           r_ptr;
    logic [3:0]           r_ccl;
    logic [3:0]           r_cc [NUM_STREAMS];

    logic [7:0]           w_ptr  [NUM_STREAMS];
    logic [12:0]          w_pid  [NUM_STREAMS];
    logic [7:0]           w_data [NUM_STREAMS];

    generate
        for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_unpack
            assign w_ptr[g]  = pointer_in[g*8 +: 8];
            assign w_pid[g]  = pid_in[g*13 +: 13];
            assign w_data[g] = data_in[g*8 +: 8];
        end
    endgenerate

    // Winner is the requester with the smallest rotational distance from r_rr.
    logic                 w_win;
    logic [c_sel_w-1:0]   w_idx;
    int                   w_best;
    int                   w_dist;

    always_comb begin
        w_win  = 1'b0;
        w_idx  = '0;
        w_best = NUM_STREAMS;
        w_dist = 0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (i >= int'(r_rr)) begin
                w_dist = i - int'(r_rr);
            end else begin
                w_dist = i + NUM_STREAMS - int'(r_rr);
            end
            if (enable[i] && ready[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = 1'b1;
                w_idx  = c_sel_w'(i);
            end
        end
    end

    logic [c_sel_w-1:0]   w_rr_next;
    assign w_rr_next = (w_idx == c_sel_w'(NUM_STREAMS - 1)) ? '0 : (w_idx + 1'b1);

    logic [NUM_STREAMS-1:0] w_onehot;
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_onehot[i] = (r_sel == c_sel_w'(i));
        end
    end

    // A read issued while byte n is registered lands on the wire as byte n+2.
    logic [7:0] w_n;
    logic       w_in_pkt;
    logic       w_rd;
    assign w_n      = r_cnt + 8'd1;
    assign w_in_pkt = (r_state == ST_HDR) || (r_state == ST_PTR) || (r_state == ST_PAYLOAD);
    assign w_rd     = w_in_pkt && !r_null &&
                      (w_n >= (r_pusi ? 8'd3 : 8'd2)) && (w_n <= c_last_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_gap     <= 4'd0;
            r_rr      <= '0;
            r_sel     <= '0;
            r_null    <= 1'b0;
            r_pid     <= 13'd0;
            r_pusi    <= 1'b0;
            r_ptr     <= 8'd0;
            r_ccl     <= 4'd0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_cc[i] <= 4'd0;
            end
            rd_req    <= '0;
            data_out  <= 8'd0;
            ena_out   <= 1'b0;
            psync_out <= 1'b0;
            grant_id  <= 3'd7;
        end else begin
            rd_req    <= w_rd ? w_onehot : '0;
            psync_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_win) begin
                        r_sel     <= w_idx;
                        r_null    <= 1'b0;
                        r_pid     <= w_pid[w_idx];
                        r_pusi    <= pusi[w_idx];
                        r_ptr     <= w_ptr[w_idx];
                        r_ccl     <= r_cc[w_idx];
                        r_rr      <= w_rr_next;
                        grant_id  <= 3'(w_idx);
                        data_out  <= c_sync;
                        ena_out   <= 1'b1;
                        psync_out <= 1'b1;
                        r_state   <= ST_HDR;
                    end else if (NULL_FILL) begin
                        r_sel     <= '0;
                        r_null    <= 1'b1;
                        r_pid     <= c_null_pid;
                        r_pusi    <= 1'b0;
                        r_ptr     <= 8'd0;
                        r_ccl     <= 4'd0;
                        grant_id  <= 3'd7;
                        data_out  <= c_sync;
                        ena_out   <= 1'b1;
                        psync_out <= 1'b1;
                        r_state   <= ST_HDR;
                    end else begin
                        data_out  <= 8'd0;
                        ena_out   <= 1'b0;
                    end
                end
                ST_HDR: begin
                    r_cnt <= w_n;
                    if (r_cnt == 8'd0) begin
                        data_out <= {1'b0, r_pusi, 1'b0, r_pid[12:8]};
                    end else if (r_cnt == 8'd1) begin
                        data_out <= r_pid[7:0];
                    end else begin
                        data_out <= {4'b0001, r_ccl};
                        r_state  <= r_pusi ? ST_PTR : ST_PAYLOAD;
                    end
                end
                ST_PTR: begin
                    r_cnt    <= w_n;
                    data_out <= r_ptr;
                    r_state  <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    r_cnt    <= w_n;
                    data_out <= r_null ? 8'hFF : w_data[r_sel];
                    if (w_n == c_last) begin
                        if (!r_null) begin
                            r_cc[r_sel] <= r_ccl + 4'd1;
                        end
                        r_gap   <= c_gap_init;
                        r_state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    data_out <= 8'd0;
                    ena_out  <= 1'b0;
                    if (r_gap == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t2mi_ts_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_t2mi_ts_mux
// Purpose  : Randomized bench for t2mi_ts_mux against a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t2mi_ts_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 4 streams, null fill, no gap
    logic [3:0]  en_a, rdy_a, pusi_a;
    logic [31:0] ptr_a_bus, data_a_bus;
    logic [51:0] pid_a_bus;
    logic [3:0]  rd_a;
    logic [7:0]  dout_a;
    logic        ena_a, psync_a;
    logic [2:0]  gid_a;

    // DUT B: 2 streams, no null fill, 3-cycle gap
    logic        rdy_b_on;
    logic [1:0]  rd_b;
    logic [7:0]  dout_b;
    logic        ena_b, psync_b;
    logic [2:0]  gid_b;

    logic [12:0] s_pid [4];
    logic [7:0]  s_ptr [4];
    int          fifo_cnt [4];

    t2mi_ts_mux #(.NUM_STREAMS(4), .NULL_FILL(1'b1), .GAP(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .ready(rdy_a), .pusi(pusi_a),
        .pointer_in(ptr_a_bus), .pid_in(pid_a_bus), .data_in(data_a_bus),
        .rd_req(rd_a), .data_out(dout_a), .ena_out(ena_a), .psync_out(psync_a),
        .grant_id(gid_a));

    t2mi_ts_mux #(.NUM_STREAMS(2), .NULL_FILL(1'b0), .GAP(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(2'b11), .ready({2{rdy_b_on}}), .pusi(2'b00),
        .pointer_in(16'h0000), .pid_in({13'h0200, 13'h0100}), .data_in(16'hA55A),
        .rd_req(rd_b), .data_out(dout_b), .ena_out(ena_b), .psync_out(psync_b),
        .grant_id(gid_b));

    function automatic logic [7:0] fbyte(int s, int k);
        return 8'(s * 37 + k * (2 * s + 1));
    endfunction

    // Upstream FIFOs: each read strobe returns the next byte of that stream.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_cnt[i] <= 0;
            data_a_bus <= 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rd_a[i]) begin
                    data_a_bus[i*8 +: 8] <= fbyte(i, fifo_cnt[i]);
                    fifo_cnt[i]          <= fifo_cnt[i] + 1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model state for DUT A
    bit          a_in, a_fresh;
    int          a_idx, a_s, a_rr, a_rdn;
    logic [12:0] a_pid;
    logic        a_pusi;
    logic [7:0]  a_ptr;
    logic [3:0]  a_ccv;
    logic [3:0]  a_cc [4];
    int          a_fidx [4];

    // Reference model state for DUT B
    bit          b_in, b_seen;
    int          b_len, b_idle, b_s, b_rr;
    logic [3:0]  b_cc [2];

    task automatic model_reset();
        a_in = 0; a_fresh = 1; a_idx = 0; a_s = -1; a_rr = 0; a_rdn = 0;
        for (int i = 0; i < 4; i++) begin a_cc[i] = 4'd0; a_fidx[i] = 0; end
        b_in = 0; b_seen = 0; b_len = 0; b_idle = 0; b_s = 0; b_rr = 0;
        b_cc[0] = 4'd0; b_cc[1] = 4'd0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_a_data", 32'(dout_a), 32'h0);
        chk("rst_a_ena", 32'(ena_a), 32'h0);
        chk("rst_a_psync", 32'(psync_a), 32'h0);
        chk("rst_a_rd", 32'(rd_a), 32'h0);
        chk("rst_a_gid", 32'(gid_a), 32'h7);
        chk("rst_b_ena", 32'(ena_b), 32'h0);
        chk("rst_b_gid", 32'(gid_b), 32'h7);
    endtask

    task automatic mon_a();
        logic [7:0] exp;
        logic [3:0] own;
        if (!a_in) begin
            if (!ena_a) begin
                if (!a_fresh) chk("a_contiguous", 32'(ena_a), 32'h1);
                return;
            end
            a_fresh = 0;
            a_s = -1;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (a_rr + k) % 4;
                if (a_s < 0 && en_a[j] && rdy_a[j]) a_s = j;
            end
            if (a_s >= 0) begin
                a_pid = s_pid[a_s]; a_pusi = pusi_a[a_s]; a_ptr = s_ptr[a_s];
                a_ccv = a_cc[a_s];  a_rr = (a_s + 1) % 4;
            end else begin
                a_pid = 13'h1FFF; a_pusi = 1'b0; a_ptr = 8'd0; a_ccv = 4'd0;
            end
            chk("a_grant", 32'(gid_a), (a_s < 0) ? 32'd7 : 32'(a_s));
            a_in = 1; a_idx = 0; a_rdn = 0;
        end else begin
            a_idx++;
            chk("a_ena", 32'(ena_a), 32'h1);
        end
        case (a_idx)
            0:       exp = 8'h47;
            1:       exp = {1'b0, a_pusi, 1'b0, a_pid[12:8]};
            2:       exp = a_pid[7:0];
            3:       exp = {4'h1, a_ccv};
            default: begin
                if (a_idx == 4 && a_pusi) exp = a_ptr;
                else if (a_s < 0) exp = 8'hFF;
                else begin
                    exp = fbyte(a_s, a_fidx[a_s]);
                    a_fidx[a_s]++;
                end
            end
        endcase
        chk("a_byte", 32'(dout_a), 32'(exp));
        chk("a_psync", 32'(psync_a), (a_idx == 0) ? 32'h1 : 32'h0);
        own = (a_s < 0) ? 4'h0 : (4'h1 << a_s);
        chk("a_rd_owner", 32'(rd_a & ~own), 32'h0);
        if (a_s >= 0 && rd_a[a_s]) a_rdn++;
        if (a_idx == 187) begin
            chk("a_rd_count", 32'(a_rdn), (a_s < 0) ? 32'd0 : 32'(184 - int'(a_pusi)));
            if (a_s >= 0) a_cc[a_s] = a_cc[a_s] + 4'd1;
            a_in = 0;
        end
    endtask

    task automatic mon_b(input int cyc);
        if (!rdy_b_on) chk("b_idle_no_fill", 32'(ena_b), 32'h0);
        if (ena_b) begin
            if (!b_in) begin
                if (b_seen) chk("b_gap", 32'(b_idle), 32'd3);
                chk("b_grant", 32'(gid_b), 32'(b_rr));
                chk("b_sync", 32'(dout_b), 32'h47);
                b_s = b_rr; b_rr ^= 1; b_in = 1; b_len = 0;
            end
            if (b_len == 3) chk("b_cc", 32'(dout_b), 32'({4'h1, b_cc[b_s]}));
            b_len++;
        end else begin
            if (b_in) begin
                chk("b_len", 32'(b_len), 32'd188);
                b_cc[b_s] = b_cc[b_s] + 4'd1;
                b_in = 0; b_seen = 1; b_idle = 0;
            end
            b_idle++;
        end
    endtask

    task automatic drive(input int mode, input int cyc);
        for (int i = 0; i < 4; i++) begin
            s_pid[i]  = 13'($urandom);
            s_ptr[i]  = 8'($urandom_range(182, 0));
        end
        pusi_a = 4'($urandom);
        en_a   = 4'($urandom) | 4'($urandom);
        rdy_a  = 4'($urandom);
        case (mode)
            0: begin en_a = 4'hF; rdy_a = 4'h1; s_pid[0] = 13'h1000; pusi_a[0] = 1'b1; s_ptr[0] = 8'h05; end
            1: begin en_a = 4'hF; rdy_a = 4'h1; pusi_a[0] = 1'b0; end
            2: begin en_a = 4'b1101; rdy_a = 4'hF; end
            3: begin rdy_a = 4'h0; end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            pid_a_bus[i*13 +: 13] = s_pid[i];
            ptr_a_bus[i*8 +: 8]   = s_ptr[i];
        end
        rdy_b_on = (cyc >= 50);
    endtask

    initial begin
        bit rst_done;
        int mode;
        rst_done = 0;
        model_reset();
        drive(0, 0);
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 14000; cyc++) begin
            @(negedge clk);
            mon_a();
            mon_b(cyc);
            if (!rst_done && cyc >= 13000 && a_in && a_s >= 0 && a_idx == 100) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs();
                model_reset();
                rst_done = 1;
                repeat (2) @(negedge clk);
                chk_reset_outputs();
                rst_n = 1'b1;
            end
            if (cyc < 190)       mode = 0;
            else if (cyc < 3400) mode = 1;
            else if (cyc < 4600) mode = 2;
            else if (cyc < 5000) mode = 3;
            else if (!rst_done)  mode = 4;
            else                 mode = 1;
            drive(mode, cyc);
        end
        chk("reset_reached", 32'(rst_done), 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
